// File: rtl/mem_pkg.sv
// mem_pkg: shared size encodings, FSM states and default latency for the data memory
package mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;
  localparam int LATENCY_DEF = 2;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: 2^ADDR_W x 32 synchronous RAM, byte-enable write, registered read
module dmem_array #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  logic [31:0] mem [2**ADDR_W];
  logic [31:0] rdata_q;
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    rdata_q <= mem[addr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: single-outstanding data memory with fixed latency and alignment/range checks
module data_mem_resp import mem_pkg::*; #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam logic [2:0] CNT_LAST = 3'(LATENCY == 0 ? 0 : LATENCY - 1);
  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q, we_d, uns_q, uns_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        idle, accept, go_resp, err, c_we;
  logic [1:0]  c_size, off;
  logic [31:0] c_addr, c_wdata, wd, rd, sh, ld;
  logic [3:0]  be;
  // In IDLE the RAM sees the live request so LATENCY = 0 still reads/writes on the accept edge
  always_comb begin
    idle    = state_q == ST_IDLE;
    accept  = idle && req_valid;
    c_we    = idle ? req_we : we_q;
    c_addr  = idle ? req_addr : addr_q;
    c_size  = idle ? req_size : size_q;
    c_wdata = idle ? req_wdata : wdata_q;
    off     = c_addr[1:0];
    err     = c_size == SZ_RSVD || (c_size == SZ_HALF && off[0]) ||
              (c_size == SZ_WORD && off != 2'd0) || (c_addr >> (ADDR_W + 2)) != 32'd0;
    be      = c_size == SZ_BYTE ? 4'b0001 << off : c_size == SZ_HALF ? 4'b0011 << off : 4'b1111;
    wd      = c_size == SZ_BYTE ? {4{c_wdata[7:0]}} : c_size == SZ_HALF ? {2{c_wdata[15:0]}} : c_wdata;
    go_resp = (accept && LATENCY == 0) || (state_q == ST_WAIT && cnt_q == CNT_LAST);
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    if (accept) begin
      we_d    = req_we;
      addr_d  = req_addr;
      size_d  = req_size;
      uns_d   = req_unsigned;
      wdata_d = req_wdata;
      cnt_d   = 3'd0;
      state_d = LATENCY == 0 ? ST_RESP : ST_WAIT;
    end else if (state_q == ST_WAIT) begin
      cnt_d   = cnt_q + 3'd1;
      state_d = go_resp ? ST_RESP : ST_WAIT;
    end else if (state_q == ST_RESP) begin
      state_d = ST_IDLE;
    end
    sh         = rd >> {off, 3'b000};
    ld         = c_size == SZ_BYTE ? {{24{~uns_q & sh[7]}}, sh[7:0]} :
                 c_size == SZ_HALF ? {{16{~uns_q & sh[15]}}, sh[15:0]} : sh;
    req_ready  = idle;
    resp_valid = state_q == ST_RESP;
    resp_err   = resp_valid && err;
    resp_rdata = (resp_valid && !err && !we_q) ? ld : 32'd0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
    end
  end
  dmem_array #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (go_resp && c_we && !err && rst),
    .be    (be),
    .addr  (c_addr[ADDR_W+1:2]),
    .wdata (wd),
    .rdata (rd)
  );
endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: scoreboard-driven bench for data_mem_resp with LATENCY = 2, ADDR_W = 8
module tb_data_mem_resp;
  logic        clk = 1'b0, rst = 1'b0, req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic [1:0]  req_size = 2'd0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [32:0] exp_q[$];
  int n_checks = 0, n_fail = 0;

  data_mem_resp #(.ADDR_W(8), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic xact(input logic we, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wdata,
                      input logic [31:0] exp_data, input logic exp_err, input string name);
    logic [32:0] e;
    int lat = 0;
    @(negedge clk);
    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
    req_valid = 1'b1;
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL %s ready: got %b want 1", name, req_ready); end
    @(posedge clk);
    #1 req_valid = 1'b0;
    exp_q.push_back({exp_err, exp_data});
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) lat = i;
      else begin
        n_checks++;
        if (resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
          n_fail++; $display("FAIL %s idle_outputs: got rdata=%h err=%b want 0/0", name, resp_rdata, resp_err);
        end
      end
    end
    n_checks++;
    if (lat != 3) begin n_fail++; $display("FAIL %s latency: got %0d want 3", name, lat); end
    if (lat != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (resp_rdata !== e[31:0] || resp_err !== e[32]) begin
        n_fail++; $display("FAIL %s resp: got rdata=%h err=%b want rdata=%h err=%b", name, resp_rdata, resp_err, e[31:0], e[32]);
      end
    end else void'(exp_q.pop_front());
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
      n_fail++; $display("FAIL reset: got ready=%b valid=%b rdata=%h err=%b want 1/0/0/0", req_ready, resp_valid, resp_rdata, resp_err);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_word();
    xact(1'b1, 32'h10, 2'd2, 1'b0, 32'h12345678, 32'd0, 1'b0, "sw_0x10");
    xact(1'b0, 32'h10, 2'd2, 1'b0, 32'd0, 32'h12345678, 1'b0, "lw_0x10");
  endtask

  task automatic test_subword();
    xact(1'b1, 32'h20, 2'd2, 1'b0, 32'h80FF7F01, 32'd0, 1'b0, "sw_0x20");
    xact(1'b0, 32'h22, 2'd0, 1'b0, 32'd0, 32'hFFFFFFFF, 1'b0, "lb_0x22");
    xact(1'b0, 32'h23, 2'd0, 1'b1, 32'd0, 32'h00000080, 1'b0, "lbu_0x23");
    xact(1'b0, 32'h22, 2'd1, 1'b0, 32'd0, 32'hFFFF80FF, 1'b0, "lh_0x22");
    xact(1'b0, 32'h20, 2'd1, 1'b1, 32'd0, 32'h00007F01, 1'b0, "lhu_0x20");
    xact(1'b0, 32'h21, 2'd0, 1'b0, 32'd0, 32'h0000007F, 1'b0, "lb_0x21");
  endtask

  task automatic test_byte_store();
    xact(1'b1, 32'h20, 2'd2, 1'b0, 32'h00000000, 32'd0, 1'b0, "sw0_0x20");
    xact(1'b1, 32'h21, 2'd0, 1'b0, 32'hFFFFFFAB, 32'd0, 1'b0, "sb_0x21");
    xact(1'b0, 32'h20, 2'd2, 1'b0, 32'd0, 32'h0000AB00, 1'b0, "lw_after_sb");
    xact(1'b1, 32'h22, 2'd1, 1'b0, 32'h1234BEEF, 32'd0, 1'b0, "sh_0x22");
    xact(1'b0, 32'h20, 2'd2, 1'b0, 32'd0, 32'hBEEFAB00, 1'b0, "lw_after_sh");
  endtask

  task automatic test_errors();
    xact(1'b1, 32'h00, 2'd2, 1'b0, 32'hCAFEF00D, 32'd0, 1'b0, "sw_0x00");
    xact(1'b0, 32'h02, 2'd2, 1'b0, 32'd0, 32'd0, 1'b1, "lw_0x02");
    xact(1'b1, 32'h01, 2'd1, 1'b0, 32'h0000FFFF, 32'd0, 1'b1, "sh_0x01");
    xact(1'b0, 32'h400, 2'd2, 1'b0, 32'd0, 32'd0, 1'b1, "lw_0x400");
    xact(1'b1, 32'h400, 2'd2, 1'b0, 32'h55555555, 32'd0, 1'b1, "sw_0x400");
    xact(1'b0, 32'h00, 2'd3, 1'b0, 32'd0, 32'd0, 1'b1, "size3");
    xact(1'b0, 32'h00, 2'd2, 1'b0, 32'd0, 32'hCAFEF00D, 1'b0, "lw_0x00_kept");
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    xact(1'b1, 32'h30, 2'd2, 1'b0, 32'h11111111, 32'd0, 1'b0, "sw_0x30_prior");
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h30; req_size = 2'd2; req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid immediate: got ready=%b valid=%b want 1/0", req_ready, resp_valid);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) rst = 1'b1;
      if (resp_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL reset_mid resp_valid: got %0d strobes want 0", seen); end
    xact(1'b0, 32'h30, 2'd2, 1'b0, 32'd0, 32'h11111111, 1'b0, "lw_0x30_after_reset");
  endtask

  task automatic test_back_to_back();
    logic [32:0] e;
    int accepts = 0, last = -1, resps = 0;
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h10; req_size = 2'd2; req_unsigned = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      if (resp_valid === 1'b1) begin
        resps++;
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b unexpected_resp: got resp at cycle %0d want none", i); end
        else begin
          e = exp_q.pop_front();
          if (resp_rdata !== e[31:0] || resp_err !== e[32]) begin
            n_fail++; $display("FAIL b2b resp: got rdata=%h err=%b want %h/%b", resp_rdata, resp_err, e[31:0], e[32]);
          end
        end
      end
      if (req_ready === 1'b1) begin
        n_checks++;
        if (resp_valid === 1'b1 || (last >= 0 && i - last != 4)) begin
          n_fail++; $display("FAIL b2b ready_gap: got gap %0d valid=%b want 4/0", i - last, resp_valid);
        end
        last = i;
        accepts++;
        exp_q.push_back({1'b0, 32'h12345678});
      end
    end
    req_valid = 1'b0;
    n_checks++;
    if (accepts != 4 || resps != 4 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b counts: got accepts=%0d resps=%0d pending=%0d want 4/4/0", accepts, resps, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_byte_store();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
